// File: rtl/serial_magnitude_comparator_if.sv
// Operand/handshake/result bundle for the serial magnitude comparator.
// The master drives start and the operands; the slave (the comparator) returns busy, done and the three flags.
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             lesser;
   logic             equals;
   logic             greater;

   modport master (
      output start, a, b,
      input  busy, done, lesser, equals, greater
   );

   modport slave (
      input  start, a, b,
      output busy, done, lesser, equals, greater
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first compare of two latched operands. done pulses k cycles after start: k = 1..WIDTH with SERIAL_CMP_EARLY_EXIT_EN,
// otherwise always WIDTH. start is ignored while busy; flags hold until the next result.
module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input logic                          clk,
   input logic                          rst,
   serial_magnitude_comparator_if.slave cmp
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, COMPARE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic             lesser_q, lesser_d;
   logic             equals_q, equals_d;
   logic             greater_q, greater_d;
   logic             bit_a, bit_b;
   logic             commit, res_lt, res_gt;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
   // First differing bit seen so far; later bits must not override it.
   logic             diff_q, diff_d;
   logic             dgt_q, dgt_d;
`endif

   assign bit_a = a_q[idx_q];
   assign bit_b = b_q[idx_q];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      lesser_d  = lesser_q;
      equals_d  = equals_q;
      greater_d = greater_q;
      commit    = 1'b0;
      res_lt    = 1'b0;
      res_gt    = 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      diff_d    = diff_q;
      dgt_d     = dgt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmp.start) begin
               a_d     = cmp.a;
               b_d     = cmp.b;
               idx_d   = IDX_W'(WIDTH - 1);
               state_d = COMPARE;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
               diff_d  = 1'b0;
               dgt_d   = 1'b0;
`endif
            end
         end
         COMPARE: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            if (bit_a != bit_b) begin
               commit = 1'b1;
               res_lt = bit_b;
               res_gt = bit_a;
            end else if (idx_q == '0) begin
               commit = 1'b1;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
`else
            if (!diff_q && (bit_a != bit_b)) begin
               diff_d = 1'b1;
               dgt_d  = bit_a;
            end
            if (idx_q == '0) begin
               commit = 1'b1;
               if (diff_q) begin
                  res_gt = dgt_q;
                  res_lt = !dgt_q;
               end else begin
                  res_gt = bit_a & !bit_b;
                  res_lt = bit_b & !bit_a;
               end
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (commit) begin
         state_d   = IDLE;
         done_d    = 1'b1;
         lesser_d  = res_lt;
         greater_d = res_gt;
         equals_d  = !(res_lt | res_gt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         lesser_q  <= 1'b0;
         equals_q  <= 1'b0;
         greater_q <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
         diff_q    <= 1'b0;
         dgt_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         lesser_q  <= lesser_d;
         equals_q  <= equals_d;
         greater_q <= greater_d;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
         diff_q    <= diff_d;
         dgt_q     <= dgt_d;
`endif
      end
   end

   assign cmp.busy    = (state_q == COMPARE);
   assign cmp.done    = done_q;
   assign cmp.lesser  = lesser_q;
   assign cmp.equals  = equals_q;
   assign cmp.greater = greater_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: directed scenarios plus randomized back-to-back compares against an arithmetic model.
module tb_serial_magnitude_comparator;
   localparam int WIDTH = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   serial_magnitude_comparator_if #(.WIDTH(WIDTH)) cif ();

   serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .cmp (cif)
   );

   always #5 clk = ~clk;

   // Bits examined until the first MSB-first difference (WIDTH if equal); fixed WIDTH without early exit.
   function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x;
      int first;
      x = a ^ b;
      first = WIDTH;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i]) begin
            first = WIDTH - i;
            break;
         end
      end
      return EARLY ? first : WIDTH;
   endfunction

   function automatic logic [2:0] exp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return {a < b, a == b, a > b};
   endfunction

   // Issues start in the current cycle and waits (bounded) for done; lat = -1 on timeout.
   task automatic do_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             output int lat, output int busy_cnt, output logic [2:0] flags);
      cif.start = 1'b1;
      cif.a     = a;
      cif.b     = b;
      @(posedge clk); #1;
      cif.start = 1'b0;
      cif.a     = WIDTH'($urandom);
      cif.b     = WIDTH'($urandom);
      busy_cnt  = cif.busy ? 1 : 0;
      lat       = -1;
      flags     = 3'b000;
      for (int c = 1; c <= WIDTH + 4; c++) begin
         @(posedge clk); #1;
         if (cif.done) begin
            lat   = c;
            flags = {cif.lesser, cif.equals, cif.greater};
            break;
         end
         if (cif.busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cif.start = 1'b1;
      cif.a = 8'h05;
      cif.b = 8'h03;
      repeat (2) @(posedge clk);
      #1;
      total++; if (cif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", cif.busy); end
      total++; if (cif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", cif.done); end
      total++;
      if ({cif.lesser, cif.equals, cif.greater} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {cif.lesser, cif.equals, cif.greater});
      end
      rst = 1'b0;
      cif.start = 1'b0;
      @(posedge clk); #1;
      total++; if (cif.busy !== 1'b0) begin bad++; $display("FAIL reset_no_start got=%b want=0", cif.busy); end
   endtask

   task automatic test_msb_decide();
      int lat, bc;
      logic [2:0] fl;
      do_compare(8'h80, 8'h7F, lat, bc, fl);
      total++; if (fl !== exp_flags(8'h80, 8'h7F)) begin bad++; $display("FAIL msb_flags got=%b want=%b", fl, exp_flags(8'h80, 8'h7F)); end
      total++; if (lat !== exp_latency(8'h80, 8'h7F)) begin bad++; $display("FAIL msb_latency got=%0d want=%0d", lat, exp_latency(8'h80, 8'h7F)); end
   endtask

   task automatic test_equality();
      int lat, bc;
      logic [2:0] fl;
      do_compare(8'hA5, 8'hA5, lat, bc, fl);
      total++; if (fl !== exp_flags(8'hA5, 8'hA5)) begin bad++; $display("FAIL eq_flags got=%b want=%b", fl, exp_flags(8'hA5, 8'hA5)); end
      total++; if (lat !== WIDTH) begin bad++; $display("FAIL eq_latency got=%0d want=%0d", lat, WIDTH); end
      total++; if (bc !== WIDTH) begin bad++; $display("FAIL eq_busy_cycles got=%0d want=%0d", bc, WIDTH); end
   endtask

   task automatic test_lsb_ignored_start();
      int lat;
      cif.start = 1'b1;
      cif.a = 8'h10;
      cif.b = 8'h11;
      @(posedge clk); #1;
      cif.start = 1'b0;
      lat = -1;
      for (int c = 1; c <= WIDTH + 4; c++) begin
         cif.start = (c == 2);
         if (c == 2) cif.a = 8'hFF;
         @(posedge clk); #1;
         if (cif.done) begin lat = c; break; end
      end
      cif.start = 1'b0;
      total++; if ({cif.lesser, cif.equals, cif.greater} !== exp_flags(8'h10, 8'h11)) begin
         bad++; $display("FAIL lsb_flags got=%b want=%b", {cif.lesser, cif.equals, cif.greater}, exp_flags(8'h10, 8'h11));
      end
      total++; if (lat !== exp_latency(8'h10, 8'h11)) begin bad++; $display("FAIL lsb_latency got=%0d want=%0d", lat, exp_latency(8'h10, 8'h11)); end
      @(posedge clk); #1;
      total++; if (cif.busy !== 1'b0) begin bad++; $display("FAIL lsb_ignored_start busy got=%b want=0", cif.busy); end
   endtask

   task automatic test_back_to_back();
      int lat, bc, held_bad;
      logic [2:0] fl;
      do_compare(8'd3, 8'd3, lat, bc, fl);
      total++; if (fl !== 3'b010) begin bad++; $display("FAIL b2b_first_flags got=%b want=010", fl); end
      cif.start = 1'b1;
      cif.a = 8'h02;
      cif.b = 8'h40;
      @(posedge clk); #1;
      cif.start = 1'b0;
      total++; if (cif.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", cif.busy); end
      held_bad = 0;
      lat = -1;
      if ({cif.lesser, cif.equals, cif.greater} !== 3'b010) held_bad++;
      for (int c = 1; c <= WIDTH + 4; c++) begin
         @(posedge clk); #1;
         if (cif.done) begin lat = c; break; end
         if ({cif.lesser, cif.equals, cif.greater} !== 3'b010) held_bad++;
      end
      total++; if (held_bad !== 0) begin bad++; $display("FAIL b2b_flags_held got=%0d bad cycles want=0", held_bad); end
      total++; if (lat !== exp_latency(8'h02, 8'h40)) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, exp_latency(8'h02, 8'h40)); end
      total++; if ({cif.lesser, cif.equals, cif.greater} !== exp_flags(8'h02, 8'h40)) begin
         bad++; $display("FAIL b2b_second_flags got=%b want=%b", {cif.lesser, cif.equals, cif.greater}, exp_flags(8'h02, 8'h40));
      end
   endtask

   task automatic test_reset_midop();
      int lat, bc, done_seen;
      logic [2:0] fl;
      @(posedge clk); #1;
      cif.start = 1'b1;
      cif.a = 8'h01;
      cif.b = 8'h00;
      @(posedge clk); #1;
      cif.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (cif.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", cif.busy); end
      total++; if ({cif.done, cif.lesser, cif.equals, cif.greater} !== 4'b0000) begin
         bad++; $display("FAIL midrst_outputs got=%b want=0000", {cif.done, cif.lesser, cif.equals, cif.greater});
      end
      done_seen = 0;
      repeat (WIDTH + 2) begin
         @(posedge clk); #1;
         if (cif.done || cif.busy) done_seen++;
      end
      total++; if (done_seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d active cycles want=0", done_seen); end
      do_compare(8'h01, 8'h00, lat, bc, fl);
      total++; if (fl !== 3'b001) begin bad++; $display("FAIL midrst_after_flags got=%b want=001", fl); end
      total++; if (lat !== exp_latency(8'h01, 8'h00)) begin bad++; $display("FAIL midrst_after_latency got=%0d want=%0d", lat, exp_latency(8'h01, 8'h00)); end
   endtask

   task automatic test_random();
      int lat, bc;
      logic [2:0] fl;
      logic [WIDTH-1:0] ra, rb;
      for (int n = 0; n < 300; n++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            default: rb = WIDTH'($urandom);
         endcase
         do_compare(ra, rb, lat, bc, fl);
         total++; if (fl !== exp_flags(ra, rb)) begin bad++; $display("FAIL rnd_flags a=%h b=%h got=%b want=%b", ra, rb, fl, exp_flags(ra, rb)); end
         total++; if (lat !== exp_latency(ra, rb)) begin bad++; $display("FAIL rnd_latency a=%h b=%h got=%0d want=%0d", ra, rb, lat, exp_latency(ra, rb)); end
         total++; if (bc !== exp_latency(ra, rb)) begin bad++; $display("FAIL rnd_busy a=%h b=%h got=%0d want=%0d", ra, rb, bc, exp_latency(ra, rb)); end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      rst = 1'b1;
      cif.start = 1'b0;
      cif.a = '0;
      cif.b = '0;
      test_reset();
      test_msb_decide();
      test_equality();
      test_lsb_ignored_start();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit operands.
- Resolves lesser / equals / greater by running a one-bit compare per clock, MSB first, over latched operands.
- Drives the same three-flag result interface as the one-bit comparator, extended to words with a start/busy/done handshake.
- Sits between operand registers and control logic that needs ordered compares without a wide combinational comparator.

Parameters:
- WIDTH, 8: operand width in bits, minimum 1.
- IDX_W, $clog2(WIDTH) with a minimum of 1: width of the internal bit-index counter. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A (unsigned); sampled with start.
- b  input  WIDTH  operand B (unsigned); sampled with start.
- busy  output  1  high while a compare is in progress (state COMPARE).
- done  output  1  one-cycle pulse: result flags are valid and updated.
- lesser  output  1  a < b; registered, held until the next result.
- equals  output  1  a == b; registered, held until the next result.
- greater  output  1  a > b; registered, held until the next result.

Behaviour:
- Reset: rst sampled high at a clk edge gives state=IDLE, busy=0, done=0, lesser=0, equals=0, greater=0, and clears the index and operand registers.
- Reset mid-COMPARE aborts the operation. No done pulse is produced and the flags go to 0.
- States: IDLE, COMPARE.
- IDLE:
  - start=1 at an edge latches a and b, sets idx=WIDTH-1, moves to COMPARE and sets busy=1.
  - done is cleared on every edge that does not decide a result.
- COMPARE: each edge examines bit idx of the latched operands.
  - a[idx]=0, b[idx]=1: set lesser=1, equals=0, greater=0; done=1; busy=0; go to IDLE.
  - a[idx]=1, b[idx]=0: set greater=1, lesser=0, equals=0; done=1; busy=0; go to IDLE.
  - Bits equal and idx==0: set equals=1, lesser=0, greater=0; done=1; busy=0; go to IDLE.
  - Bits equal and idx>0: decrement idx and stay in COMPARE.
- start is ignored while busy=1. Operands are not re-sampled and no error is flagged.
- Latency: done is visible k cycles after the start edge, where k is the number of bits examined (1..WIDTH). The worst case is WIDTH.
- Back-to-back: start may be high in the cycle done=1. The new compare is accepted, busy=1 the next cycle, and the old flags stay held until the new result.
- Flags are one-hot whenever done=1. After reset, before any compare, all three are 0.
- Operand changes after the start edge have no effect.
- WIDTH=1 degenerates to a single COMPARE cycle.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: COMPARE terminates on the first differing bit as described above, giving variable latency 1..WIDTH.
- Undefined: fixed latency.
  - All WIDTH bits are always examined.
  - The first differing bit (MSB-first) is recorded internally; later bits do not alter it.
  - The result is committed with done only on the idx==0 edge, exactly WIDTH cycles after the start edge, for every operand pair.

Test Plan:
- Reset: hold rst=1 for 2 edges with start=1 -> busy=0, done=0, lesser=equals=greater=0; no compare starts.
- MSB decide (WIDTH=8): start with a=8'h80, b=8'h7F -> with EN, greater=1 and done 1 cycle after start; without EN, greater=1 and done 8 cycles after start.
- Equality: a=b=8'hA5 -> equals=1, lesser=greater=0, done after 8 cycles in both builds; busy high for exactly 8 cycles.
- LSB decide plus ignored start: a=8'h10, b=8'h11; pulse start again mid-operation with a=8'hFF -> lesser=1 after 8 cycles; the second start has no effect.
- Back-to-back: on the done cycle of a=3, b=3, assert start with a=8'h02, b=8'h40 -> equals held until the next done; then lesser=1, 2 cycles later with EN or 8 without.
- Reset mid-op: start a=8'h01, b=8'h00, assert rst after 3 cycles -> no done pulse, flags 0, IDLE; a following compare of a=1, b=0 gives greater=1.
